// File: rtl/iter_shift_unit.sv
// Iterative shifter: one bit position per clock. Done arrives shamt+1 cycles after an accepted start.
// No backpressure; a start is taken only in IDLE and ignored while busy (including the DONE cycle).
module iter_shift_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] count;

  function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] r,
                                               input logic [2:0]        o);
    logic [DATA_W-1:0] s;
    s = r;
    case (o)
      OP_SLL:  s = {r[DATA_W-2:0], 1'b0};
      OP_SRL:  s = {1'b0, r[DATA_W-1:1]};
      OP_SRA:  s = {r[DATA_W-1], r[DATA_W-1:1]};
      OP_ROL:  s = {r[DATA_W-2:0], r[DATA_W-1]};
      OP_ROR:  s = {r[0], r[DATA_W-1:1]};
      default: s = r;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      op_q   <= OP_SLL;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result <= data_in;
            op_q   <= op;
            count  <= shamt;
            // Zero amount and pass-through ops skip straight to the done cycle.
            if ((shamt != '0) && (op <= OP_ROR)) state <= SHIFT;
            else                                 state <= DONE;
          end
        end
        SHIFT: begin
          result <= shift1(result, op_q);
          count  <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
